// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the unified memory port of the pipelined MIPS core.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DDONE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ifetch_buffer.sv
// One-entry instruction buffer: valid/addr/data register, hit compare and word-granular invalidate.
module ifetch_buffer
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv_req,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic              valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              inv_match;

    // Stores are matched on the word address so a sub-word store still drops the entry.
    assign inv_match = inv_req && (inv_addr[ADDR_W-1:2] == addr_reg[ADDR_W-1:2]);
    assign hit       = valid_reg && (addr_reg == lookup_addr);
    assign data      = data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else if (fill) begin
            valid_reg <= 1'b1;
            addr_reg  <= fill_addr;
            data_reg  <= fill_data;
        end else if (inv_match) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and data accesses onto the single memory port; data wins, fetch is buffered.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IReqF,
    input  logic [ADDR_W-1:0] IAddrF,
    output logic [DATA_W-1:0] IRdataF,
    output logic              IStallF,
    input  logic              DReqM,
    input  logic              DWeM,
    input  logic [ADDR_W-1:0] DAddrM,
    input  logic [DATA_W-1:0] DWdataM,
    output logic [DATA_W-1:0] DRdataM,
    output logic              DStallM,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWdata,
    input  logic [DATA_W-1:0] MemRdata,
    input  logic              MemReady
);

    arb_state_e        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] drdata_reg;

    logic latch_d, latch_i, fill, inv_req, ld_done;
    logic ibuf_hit;

    ifetch_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ibuf (
        .clk         (clk),
        .reset       (reset),
        .fill        (fill),
        .fill_addr   (addr_reg),
        .fill_data   (MemRdata),
        .inv_req     (inv_req),
        .inv_addr    (DAddrM),
        .lookup_addr (IAddrF),
        .hit         (ibuf_hit),
        .data        (IRdataF)
    );

    assign IStallF  = IReqF && !ibuf_hit;
    assign DStallM  = DReqM && (state_reg != DDONE);
    assign DRdataM  = drdata_reg;
    assign MemAddr  = addr_reg;
    assign MemWdata = wdata_reg;

    always_comb begin
        state_next = state_reg;
        latch_d    = 1'b0;
        latch_i    = 1'b0;
        fill       = 1'b0;
        inv_req    = 1'b0;
        ld_done    = 1'b0;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (DReqM) begin
                    latch_d    = 1'b1;
                    inv_req    = DWeM;
                    state_next = DBUSY;
                end else if (IStallF) begin
                    latch_i    = 1'b1;
                    state_next = IBUSY;
                end
            end
            IBUSY: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            DBUSY: begin
                MemReq = 1'b1;
                MemWe  = we_reg;
                if (MemReady) begin
                    ld_done    = !we_reg;
                    state_next = DDONE;
                end
            end
            DDONE: begin
                // DReqM still belongs to the instruction just served; a pending fetch goes first.
                if (IStallF) begin
                    latch_i    = 1'b1;
                    state_next = IBUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            we_reg     <= 1'b0;
            wdata_reg  <= '0;
            drdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_d) begin
                addr_reg  <= DAddrM;
                we_reg    <= DWeM;
                wdata_reg <= DWdataM;
            end else if (latch_i) begin
                addr_reg <= IAddrF;
                we_reg   <= 1'b0;
            end
            if (ld_done) begin
                drdata_reg <= MemRdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a wait-state-programmable memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IReqF = 1'b0;
    logic [31:0] IAddrF = '0;
    logic [31:0] IRdataF;
    logic        IStallF;
    logic        DReqM = 1'b0;
    logic        DWeM = 1'b0;
    logic [31:0] DAddrM = '0;
    logic [31:0] DWdataM = '0;
    logic [31:0] DRdataM;
    logic        DStallM;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic [31:0] MemRdata;
    logic        MemReady;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [64:0] exp_g[$];

    logic [31:0] mem [0:255];
    int waits = 0;
    int wait_cnt;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .IReqF    (IReqF),
        .IAddrF   (IAddrF),
        .IRdataF  (IRdataF),
        .IStallF  (IStallF),
        .DReqM    (DReqM),
        .DWeM     (DWeM),
        .DAddrM   (DAddrM),
        .DWdataM  (DWdataM),
        .DRdataM  (DRdataM),
        .DStallM  (DStallM),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWdata (MemWdata),
        .MemRdata (MemRdata),
        .MemReady (MemReady)
    );

    always #5 clk = ~clk;

    assign MemRdata = mem[MemAddr[9:2]];
    assign MemReady = MemReq && (wait_cnt == waits);

    always @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (MemReq && MemReady) wait_cnt <= 0;
        else if (MemReq) wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[0]  <= 32'h20080005;
            mem[1]  <= 32'h8C090040;
            mem[2]  <= 32'hAABB0008;
            mem[3]  <= 32'h3C0C000C;
            mem[4]  <= 32'h24100010;
            mem[5]  <= 32'h24140014;
            mem[16] <= 32'h12345678;
            mem[32] <= 32'hCAFE0080;
            mem[33] <= 32'hCAFE0084;
            mem[34] <= 32'hCAFE0088;
            mem[64] <= 32'h01000100;
        end else if (MemReq && MemReady && MemWe) begin
            mem[MemAddr[9:2]] <= MemWdata;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes something.
    always @(negedge clk) begin
        if (!reset) begin
            if (IReqF && !IStallF) begin
                if (exp_i.size() == 0) chk("fetch_unexpected", {32'h0, IAddrF}, 64'hFFFF_FFFF);
                else begin
                    $display("fetch addr=%08h data=%08h", IAddrF, IRdataF);
                    chk("fetch_data", {32'h0, IRdataF}, {32'h0, exp_i.pop_front()});
                end
            end
            if (DReqM && !DStallM && !DWeM) begin
                if (exp_d.size() == 0) chk("load_unexpected", {32'h0, DAddrM}, 64'hFFFF_FFFF);
                else begin
                    $display("load addr=%08h data=%08h", DAddrM, DRdataM);
                    chk("load_data", {32'h0, DRdataM}, {32'h0, exp_d.pop_front()});
                end
            end
            if (MemReq && MemReady) begin
                if (exp_g.size() == 0) chk("grant_unexpected", {31'h0, MemWe, MemAddr}, 64'hFFFF_FFFF);
                else begin
                    logic [64:0] e;
                    e = exp_g.pop_front();
                    $display("mem access we=%0b addr=%08h", MemWe, MemAddr);
                    chk("grant_we_addr", {31'h0, MemWe, MemAddr}, {31'h0, e[64:32]});
                    if (e[64]) chk("grant_wdata", {32'h0, MemWdata}, {32'h0, e[31:0]});
                end
            end
        end
    end

    task automatic wait_fetch(inout int st);
        bit done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (!IStallF) done = 1;
            else st++;
            @(posedge clk); #1;
        end
        if (!done) chk("fetch_timeout", 64'h0, 64'h1);
        IReqF = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, input logic [31:0] d, input int exp_st);
        int st = 0;
        exp_i.push_back(d);
        IReqF  = 1'b1;
        IAddrF = a;
        wait_fetch(st);
        chk("fetch_stalls", 64'(st), 64'(exp_st));
    endtask

    task automatic do_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int exp_st);
        int st = 0;
        bit done = 0;
        if (!we) exp_d.push_back(rd);
        DReqM = 1'b1; DWeM = we; DAddrM = a; DWdataM = wd;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (!DStallM) done = 1;
            else st++;
            @(posedge clk); #1;
        end
        if (!done) chk("data_timeout", 64'h0, 64'h1);
        DReqM = 1'b0; DWeM = 1'b0;
        chk("data_stalls", 64'(st), 64'(exp_st));
    endtask

    initial begin
        int st;
        // Reset state.
        @(negedge clk);
        chk("rst_memreq", {63'h0, MemReq}, 64'h0);
        chk("rst_memwe", {63'h0, MemWe}, 64'h0);
        chk("rst_memaddr", {32'h0, MemAddr}, 64'h0);
        chk("rst_memwdata", {32'h0, MemWdata}, 64'h0);
        chk("rst_irdata", {32'h0, IRdataF}, 64'h0);
        chk("rst_drdata", {32'h0, DRdataM}, 64'h0);
        IReqF = 1'b1; IAddrF = 32'h0;
        #1 chk("rst_istall_empty_buf", {63'h0, IStallF}, 64'h1);
        IReqF = 1'b0;

        // Reset in the middle of a data access.
        @(posedge clk); #1;
        reset = 1'b0; waits = 5;
        DReqM = 1'b1; DAddrM = 32'h40;
        @(negedge clk);
        chk("grant_registered", {63'h0, MemReq}, 64'h0);
        chk("dstall_first", {63'h0, DStallM}, 64'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("dbusy_memreq", {63'h0, MemReq}, 64'h1);
        #2 reset = 1'b1; IReqF = 1'b1; IAddrF = 32'h0;
        #1;
        chk("midrst_memreq", {63'h0, MemReq}, 64'h0);
        chk("midrst_memaddr", {32'h0, MemAddr}, 64'h0);
        chk("midrst_istall", {63'h0, IStallF}, 64'h1);
        chk("midrst_dstall_idle", {63'h0, DStallM}, 64'h1);
        DReqM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; IReqF = 1'b0; DAddrM = '0; waits = 0;

        // Fetch miss with zero-wait memory, then a hit with no memory traffic.
        exp_g.push_back({1'b0, 32'h0, 32'h0});
        do_fetch(32'h0, 32'h20080005, 2);
        do_fetch(32'h0, 32'h20080005, 0);

        // Simultaneous load and fetch miss with two wait states.
        waits = 2;
        exp_g.push_back({1'b0, 32'h40, 32'h0});
        exp_g.push_back({1'b0, 32'h4, 32'h0});
        fork
            do_data(1'b0, 32'h40, 32'h0, 32'h12345678, 4);
            do_fetch(32'h4, 32'h8C090040, 8);
        join

        // Store coherency with the instruction buffer.
        waits = 0;
        exp_g.push_back({1'b0, 32'h0, 32'h0});
        do_fetch(32'h0, 32'h20080005, 2);
        exp_g.push_back({1'b1, 32'h0, 32'h0000DEAD});
        do_data(1'b1, 32'h0, 32'h0000DEAD, 32'h0, 2);
        chk("store_keeps_drdata", {32'h0, DRdataM}, {32'h0, 32'h12345678});
        exp_g.push_back({1'b0, 32'h0, 32'h0});
        do_fetch(32'h0, 32'h0000DEAD, 2);
        exp_g.push_back({1'b1, 32'h44, 32'h00005555});
        do_data(1'b1, 32'h44, 32'h00005555, 32'h0, 2);
        do_fetch(32'h0, 32'h0000DEAD, 0);

        // Fetch redirect while the old fetch is in flight.
        waits = 1;
        exp_g.push_back({1'b0, 32'h8, 32'h0});
        exp_g.push_back({1'b0, 32'h100, 32'h0});
        exp_i.push_back(32'h01000100);
        IReqF = 1'b1; IAddrF = 32'h8; st = 0;
        @(negedge clk);
        if (IStallF) st++;
        @(posedge clk); #1;
        IAddrF = 32'h100;
        wait_fetch(st);
        chk("redirect_stalls", 64'(st), 64'd6);
        do_fetch(32'h100, 32'h01000100, 0);
        exp_g.push_back({1'b0, 32'h8, 32'h0});
        do_fetch(32'h8, 32'hAABB0008, 3);

        // Back-to-back loads against continuous fetch misses: grants alternate.
        waits = 0;
        exp_g.push_back({1'b0, 32'h80, 32'h0});
        exp_g.push_back({1'b0, 32'hC, 32'h0});
        exp_g.push_back({1'b0, 32'h84, 32'h0});
        exp_g.push_back({1'b0, 32'h10, 32'h0});
        exp_g.push_back({1'b0, 32'h88, 32'h0});
        exp_g.push_back({1'b0, 32'h14, 32'h0});
        fork
            begin
                do_data(1'b0, 32'h80, 32'h0, 32'hCAFE0080, 2);
                do_data(1'b0, 32'h84, 32'h0, 32'hCAFE0084, 3);
                do_data(1'b0, 32'h88, 32'h0, 32'hCAFE0088, 3);
            end
            begin
                do_fetch(32'hC, 32'h3C0C000C, 4);
                do_fetch(32'h10, 32'h24100010, 3);
                do_fetch(32'h14, 32'h24140014, 3);
            end
        join

        repeat (4) @(posedge clk);
        #1;
        chk("pending_grants", 64'(exp_g.size()), 64'd0);
        chk("pending_fetches", 64'(exp_i.size()), 64'd0);
        chk("pending_loads", 64'(exp_d.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
